fetch_stage: RTL and testbench
==============================

// Module: fetch_stage
// PURPOSE
//   Front-end fetch: owns the PC, issues requests to instruction memory and buffers the responses.
//   Drives the decode handshake with pc/instr/predicted_taken/predicted_target per instruction.
//   Static predecode redirects on JAL and backward branches. A backend redirect flushes all younger state.
// PARAMETERS
//   RESET_PC  32'h0000_0000  PC fetched first after reset
//   DEPTH     4              instr buffer entries = max outstanding+buffered; power of 2, >=2
// PORTS
//   clk                   in   1   clock, rising edge
//   rst_n                 in   1   synchronous reset, active-low
//   imem_req_valid        out  1   fetch request valid
//   imem_req_ready        in   1   memory accepts request
//   imem_req_addr         out  32  word-aligned fetch address
//   imem_rsp_valid        in   1   response valid; in request order; never back-pressured
//   imem_rsp_data         in   32  instruction word
//   redirect_valid        in   1   backend redirect (mispredict/jalr resolve)
//   redirect_pc           in   32  redirect target; bits [1:0] ignored (forced 0)
//   valid_out             out  1   instruction available to decode
//   ready_in              in   1   decode accepts
//   pc_out                out  32  instruction PC
//   instr_out             out  32  instruction word
//   predicted_taken_out   out  1   static prediction
//   predicted_target_out  out  32  predicted next PC
// BEHAVIOUR
//   Reset (rst_n=0 at edge): fetch_pc=RESET_PC; buffer, PC queue empty; outstanding=0; drop_cnt=0.
//     All outputs 0 while rst_n=0 and in the first cycle after reset.
//   Credit: imem_req_valid = (buf_count + outstanding < DEPTH); combinational from registers only.
//     imem_req_addr = fetch_pc. req_fire = valid&ready -> push fetch_pc to PC queue; fetch_pc += 4.
//   Response: rsp_fire pops the PC queue and pushes {pc, instr, pred} into the instr buffer.
//     Credit guarantees no overflow. Zero-latency memory gives 1 instr/cycle.
//     If drop_cnt!=0: response discarded, no PC-queue pop, drop_cnt-=1.
//   Predecode (on the accepted response; pc = popped PC):
//     JAL (7'b1101111): taken, target = pc + imm_j.
//     Branch (7'b1100011), imm_b[31]=1: taken, target = pc + imm_b.
//     Forward branch, JALR, all else: not taken, target = pc + 4.
//     All adds are 32-bit wrap-around.
//   Predicted taken: entry is pushed; fetch_pc <= target; PC queue cleared.
//     drop_cnt <= outstanding_next = outstanding + req_fire - rsp_fire.
//     Older buffered entries are kept.
//   Backend redirect has priority over everything:
//     buffer emptied; PC queue cleared; fetch_pc <= {redirect_pc[31:2],2'b00}.
//     The same-cycle response is discarded; drop_cnt <= outstanding_next.
//     A same-cycle decode pop is still a legal handshake but carries wrong-path data.
//   Output: valid_out = buf_count!=0; fields = buffer head, registered.
//     pop = valid_out & ready_in. Fields stay stable while valid_out & !ready_in.
//   Simultaneous push+pop at any occupancy: count unchanged, order preserved.
//     Full buffer with ready_in=0 stalls requests via credit; no loss.
//   Reset mid-operation: state returns to reset values; responses already in flight must not arrive after reset.
//     The memory model is reset together with the stage.
// STRUCTURE
//   ooop_types: add fetch_pkt_t {pc, instr, predicted_taken, predicted_target}.
//   ooop_defs.vh: OPC_JAL / OPC_BRANCH / OPC_JALR opcode constants.
//     The same imm_j/imm_b field extraction is shared with the decoder.
//   Sub-module fetch_fifo: parameterised sync FIFO (WIDTH, DEPTH, flush input).
//     Instantiated twice: PC queue (32b) and instr buffer (fetch_pkt_t).
//   Top: fetch_pc, outstanding and drop_cnt counters, predecode, redirect muxing.
// TESTING
//   1 Reset, RESET_PC=0, 0-latency memory of ADDIs, ready_in=1 -> pc_out 0,4,8,... one per cycle; pred_taken=0, target=pc+4.
//   2 ready_in=0 for 10 cycles -> <=DEPTH requests accepted, valid_out held, fields stable; release -> same order, none lost.
//   3 JAL at 0x10 imm +0x20 -> entry taken=1, target 0x30; next delivered pc 0x30; 0x14.. never delivered.
//   4 BNE at 0x40 imm -8 -> taken, target 0x38; BEQ at 0x48 imm +8 -> not taken, target 0x4C.
//   5 Memory latency 3, 3 outstanding, redirect_pc=0x103 -> buffer empty next cycle; 3 responses dropped; next pc_out 0x100.
//   6 redirect_valid with valid_out&ready_in and rsp_fire same cycle -> redirect wins, no stale entry delivered.
//     Then rst_n=0 mid-stream -> valid_out=0, first request at RESET_PC.

Source files
------------

// File: rtl/fetch_stage_pkg.sv
// Shared fetch types, opcode constants and the immediate/predecode helpers.
// The immediate extraction is meant to be the same one the decoder uses.
package fetch_stage_pkg;

  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        predicted_taken;
    logic [31:0] predicted_target;
  } fetch_pkt_t;

  typedef struct packed {
    logic        taken;
    logic [31:0] target;
  } pred_t;

  function automatic logic [31:0] imm_j(input logic [31:12] hi);
    return {{12{hi[31]}}, hi[19:12], hi[20], hi[30:21], 1'b0};
  endfunction

  function automatic logic [31:0] imm_b(input logic [31:25] hi, input logic [11:7] lo);
    return {{20{hi[31]}}, lo[7], hi[30:25], lo[11:8], 1'b0};
  endfunction

  // Static prediction: JAL and backward branches taken, everything else falls through.
  function automatic pred_t predecode(input logic [31:0] pc, input logic [31:0] instr);
    pred_t p;
    p.taken  = 1'b0;
    p.target = pc + 32'd4;
    case (instr[6:0])
      OPC_JAL: begin
        p.taken  = 1'b1;
        p.target = pc + imm_j(instr[31:12]);
      end
      OPC_BRANCH: begin
        if (instr[31]) begin
          p.taken  = 1'b1;
          p.target = pc + imm_b(instr[31:25], instr[11:7]);
        end
      end
      OPC_JALR: p.taken = 1'b0;
      default:  p.taken = 1'b0;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/fetch_stage_fifo.sv
// Synchronous FIFO with a flush that empties it in one cycle.
// Used for the in-flight PC queue and for the instruction buffer.
module fetch_stage_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush_i,
  input  logic                   push_i,
  input  logic [WIDTH-1:0]       wdata_i,
  input  logic                   pop_i,
  output logic [WIDTH-1:0]       rdata_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_i) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop_i)  rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + (AW+1)'(push_i) - (AW+1)'(pop_i);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is not reset; the count alone decides what is valid.
  always_ff @(posedge clk) begin
    if (rst_n && push_i && !flush_i) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/fetch_stage.sv
// Fetch front end: PC ownership, credit-based imem requests, predecode redirect,
// backend redirect flush and the decode-facing instruction buffer.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        valid_out,
  input  logic        ready_in,
  output logic [31:0] pc_out,
  output logic [31:0] instr_out,
  output logic        predicted_taken_out,
  output logic [31:0] predicted_target_out
);

  localparam int CW    = $clog2(DEPTH) + 1;
  localparam int PKT_W = $bits(fetch_pkt_t);

  logic          start_q;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [CW-1:0] outstanding_q, outstanding_d;
  logic [CW-1:0] drop_cnt_q, drop_cnt_d;

  logic [CW-1:0] buf_count, pcq_count;
  logic [CW:0]   in_use;
  logic [31:0]   pcq_head, rsp_pc;
  fetch_pkt_t    buf_head, buf_wdata;
  pred_t         pred;
  logic          pcq_empty;
  logic          credit, req_fire, rsp_fire, rsp_drop, rsp_take, pred_redirect;
  logic          pcq_push, pcq_pop, pcq_flush, buf_push, buf_pop;

  // start_q holds requests off for the first cycle after reset.
  assign in_use   = {1'b0, buf_count} + {1'b0, outstanding_q};
  assign credit   = start_q && (in_use < (CW+1)'(DEPTH));
  assign req_fire = credit && imem_req_ready;

  assign imem_req_valid = credit;
  assign imem_req_addr  = start_q ? fetch_pc_q : 32'h0;

  assign rsp_fire  = imem_rsp_valid;
  assign rsp_drop  = rsp_fire && (drop_cnt_q != '0);
  assign rsp_take  = rsp_fire && (drop_cnt_q == '0) && !redirect_valid;
  assign pcq_empty = (pcq_count == '0);

  // An empty PC queue with a live response means zero-latency memory answered
  // the request issued this very cycle, so its PC is still fetch_pc_q.
  assign rsp_pc        = pcq_empty ? fetch_pc_q : pcq_head;
  assign pred          = predecode(rsp_pc, imem_rsp_data);
  assign pred_redirect = rsp_take && pred.taken;

  always_comb begin
    buf_wdata.pc               = rsp_pc;
    buf_wdata.instr            = imem_rsp_data;
    buf_wdata.predicted_taken  = pred.taken;
    buf_wdata.predicted_target = pred.target;
  end

  assign pcq_flush = redirect_valid || pred_redirect;
  assign pcq_push  = req_fire && !(rsp_take && pcq_empty);
  assign pcq_pop   = rsp_take && !pcq_empty;
  assign buf_push  = rsp_take;
  assign buf_pop   = valid_out && ready_in;

  always_comb begin
    outstanding_d = outstanding_q + CW'(req_fire) - CW'(rsp_fire);
    drop_cnt_d    = drop_cnt_q;
    fetch_pc_d    = fetch_pc_q;
    // Everything still in flight after this cycle belongs to the old path.
    if (redirect_valid || pred_redirect) begin
      drop_cnt_d = outstanding_d;
    end else if (rsp_drop) begin
      drop_cnt_d = drop_cnt_q - CW'(1);
    end
    if (redirect_valid) begin
      fetch_pc_d = redirect_pc & 32'hFFFF_FFFC;
    end else if (pred_redirect) begin
      fetch_pc_d = pred.target & 32'hFFFF_FFFC;
    end else if (req_fire) begin
      fetch_pc_d = fetch_pc_q + 32'd4;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      start_q       <= 1'b0;
      fetch_pc_q    <= RESET_PC;
      outstanding_q <= '0;
      drop_cnt_q    <= '0;
    end else begin
      start_q       <= 1'b1;
      fetch_pc_q    <= fetch_pc_d;
      outstanding_q <= outstanding_d;
      drop_cnt_q    <= drop_cnt_d;
    end
  end

  fetch_stage_fifo #(
    .WIDTH (32),
    .DEPTH (DEPTH)
  ) u_pc_queue (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush_i (pcq_flush),
    .push_i  (pcq_push),
    .wdata_i (fetch_pc_q),
    .pop_i   (pcq_pop),
    .rdata_o (pcq_head),
    .count_o (pcq_count)
  );

  fetch_stage_fifo #(
    .WIDTH (PKT_W),
    .DEPTH (DEPTH)
  ) u_instr_buf (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush_i (redirect_valid),
    .push_i  (buf_push),
    .wdata_i (buf_wdata),
    .pop_i   (buf_pop),
    .rdata_o (buf_head),
    .count_o (buf_count)
  );

  assign valid_out            = (buf_count != '0);
  assign pc_out               = valid_out ? buf_head.pc : 32'h0;
  assign instr_out            = valid_out ? buf_head.instr : 32'h0;
  assign predicted_taken_out  = valid_out && buf_head.predicted_taken;
  assign predicted_target_out = valid_out ? buf_head.predicted_target : 32'h0;

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: expected instruction stream queued by the
// stimulus, checked by an independent monitor on every decode handshake.
module tb_fetch_stage;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        valid_out, ready_in;
  logic [31:0] pc_out, instr_out, predicted_target_out;
  logic        predicted_taken_out;

  int n_tests = 0;
  int n_fail  = 0;
  int n_deliv = 0;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        taken;
    logic [31:0] tgt;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  always #5 clk = ~clk;

  fetch_stage #(.RESET_PC(32'h0), .DEPTH(DEPTH)) dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .imem_req_valid       (imem_req_valid),
    .imem_req_ready       (imem_req_ready),
    .imem_req_addr        (imem_req_addr),
    .imem_rsp_valid       (imem_rsp_valid),
    .imem_rsp_data        (imem_rsp_data),
    .redirect_valid       (redirect_valid),
    .redirect_pc          (redirect_pc),
    .valid_out            (valid_out),
    .ready_in             (ready_in),
    .pc_out               (pc_out),
    .instr_out            (instr_out),
    .predicted_taken_out  (predicted_taken_out),
    .predicted_target_out (predicted_target_out)
  );

  // Program image: JAL +0x20 at 0x10, BNE -8 at 0x40, BEQ +8 at 0x48, else ADDI x1,x0,pc.
  function automatic logic [31:0] img(input logic [31:0] a);
    case (a)
      32'h10:  return 32'h0200_006F;
      32'h40:  return 32'hFE00_1CE3;
      32'h48:  return 32'h0000_0463;
      default: return {a[11:0], 20'h00093};
    endcase
  endfunction

  // Hand-computed predictions for the image above.
  task automatic push_stream(input logic [31:0] start, input int n);
    logic [31:0] pc;
    exp_t e;
    pc = start;
    for (int i = 0; i < n; i++) begin
      e.pc    = pc;
      e.instr = img(pc);
      case (pc)
        32'h10:  begin e.taken = 1'b1; e.tgt = 32'h30; end
        32'h40:  begin e.taken = 1'b1; e.tgt = 32'h38; end
        32'h48:  begin e.taken = 1'b0; e.tgt = 32'h4C; end
        default: begin e.taken = 1'b0; e.tgt = pc + 32'd4; end
      endcase
      exp_q.push_back(e);
      pc = e.taken ? e.tgt : pc + 32'd4;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_tests++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Fixed-latency in-order memory; latency 0 answers combinationally.
  int          lat = 0;
  logic        pv [0:7];
  logic [31:0] pa [0:7];

  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) begin
        pv[i] <= 1'b0;
        pa[i] <= 32'h0;
      end
    end else begin
      for (int i = 0; i < 7; i++) begin
        pv[i] <= pv[i+1];
        pa[i] <= pa[i+1];
      end
      pv[7] <= 1'b0;
      if (lat > 0 && imem_req_valid && imem_req_ready) begin
        pv[lat-1] <= 1'b1;
        pa[lat-1] <= imem_req_addr;
      end
    end
  end

  assign imem_rsp_valid = (lat == 0) ? (imem_req_valid & imem_req_ready) : pv[0];
  assign imem_rsp_data  = (lat == 0) ? img(imem_req_addr) : img(pa[0]);

  function automatic int inflight();
    int c = 0;
    for (int i = 0; i < 8; i++) if (pv[i]) c++;
    return c;
  endfunction

  // Handshakes in a redirect or reset cycle carry wrong-path data and are ignored.
  always @(negedge clk) begin
    if (rst_n && valid_out && ready_in && !redirect_valid) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_deliver: got pc %h, required no delivery", pc_out);
      end else begin
        mon_e = exp_q.pop_front();
        chk("pc_out", pc_out, mon_e.pc);
        chk("instr_out", instr_out, mon_e.instr);
        chk("pred_taken", {31'b0, predicted_taken_out}, {31'b0, mon_e.taken});
        chk("pred_target", predicted_target_out, mon_e.tgt);
        n_deliv++;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [31:0] cap_pc, cap_instr;
  int          acc, deliv0;
  logic        found;

  initial begin
    rst_n          = 1'b0;
    imem_req_ready = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    ready_in       = 1'b0;

    // Reset state
    tick();
    tick();
    @(negedge clk);
    chk("rst_valid_out", {31'b0, valid_out}, 32'h0);
    chk("rst_req_valid", {31'b0, imem_req_valid}, 32'h0);
    chk("rst_req_addr", imem_req_addr, 32'h0);
    chk("rst_pc_out", pc_out, 32'h0);
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    chk("first_cycle_req_valid", {31'b0, imem_req_valid}, 32'h0);
    chk("first_cycle_valid_out", {31'b0, valid_out}, 32'h0);
    push_stream(32'h0, 60);
    tick();
    ready_in = 1'b1;
    @(negedge clk);
    chk("first_req_valid", {31'b0, imem_req_valid}, 32'h1);
    chk("first_req_addr", imem_req_addr, 32'h0);

    // Sequential stream, JAL at 0x10, BNE loop at 0x40
    repeat (14) tick();

    // Decode stall: fields hold, requests limited by credit
    ready_in = 1'b0;
    acc = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (imem_req_valid && imem_req_ready) acc++;
      chk("stall_valid_out", {31'b0, valid_out}, 32'h1);
      if (i == 0) begin
        cap_pc    = pc_out;
        cap_instr = instr_out;
      end else begin
        chk("stall_pc_stable", pc_out, cap_pc);
        chk("stall_instr_stable", instr_out, cap_instr);
      end
    end
    chk("stall_reqs_le_depth", {31'b0, (acc <= DEPTH)}, 32'h1);
    tick();
    ready_in = 1'b1;
    repeat (12) tick();

    // Backend redirect to the forward-branch case at 0x48
    redirect_valid = 1'b1;
    redirect_pc    = 32'h48;
    exp_q.delete();
    push_stream(32'h48, 40);
    tick();
    redirect_valid = 1'b0;
    repeat (10) tick();

    // Latency 3, redirect with three requests in flight
    lat   = 3;
    found = 1'b0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (inflight() == 3) begin
        found = 1'b1;
        break;
      end
    end
    chk("three_outstanding", {31'b0, found}, 32'h1);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h103;
    imem_req_ready = 1'b0;
    exp_q.delete();
    push_stream(32'h100, 40);
    tick();
    redirect_valid = 1'b0;
    imem_req_ready = 1'b1;
    @(negedge clk);
    chk("flush_buffer_empty", {31'b0, valid_out}, 32'h0);
    deliv0 = n_deliv;
    repeat (15) tick();
    chk("delivered_after_0x100", {31'b0, (n_deliv > deliv0)}, 32'h1);

    // Redirect colliding with a decode pop and a response in the same cycle
    found = 1'b0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (valid_out && ready_in && imem_rsp_valid) begin
        found = 1'b1;
        break;
      end
    end
    chk("collision_found", {31'b0, found}, 32'h1);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h200;
    exp_q.delete();
    push_stream(32'h200, 40);
    tick();
    redirect_valid = 1'b0;
    @(negedge clk);
    chk("collision_buffer_empty", {31'b0, valid_out}, 32'h0);
    deliv0 = n_deliv;
    repeat (12) tick();
    chk("delivered_after_0x200", {31'b0, (n_deliv > deliv0)}, 32'h1);

    // Reset mid-stream
    rst_n = 1'b0;
    exp_q.delete();
    tick();
    @(negedge clk);
    chk("midrst_valid_out", {31'b0, valid_out}, 32'h0);
    chk("midrst_req_valid", {31'b0, imem_req_valid}, 32'h0);
    tick();
    rst_n = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (imem_req_valid) begin
        found = 1'b1;
        break;
      end
    end
    chk("midrst_req_seen", {31'b0, found}, 32'h1);
    chk("midrst_first_addr", imem_req_addr, 32'h0);
    push_stream(32'h0, 6);
    for (int i = 0; i < 80; i++) begin
      tick();
      if (exp_q.size() == 0) break;
    end
    ready_in = 1'b0;
    chk("drain_remaining", exp_q.size(), 32'h0);
    repeat (3) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
